// File: rtl/seq_chk_pkg.sv
// Shared types and helpers for the sequence period checker.
package seq_chk_pkg;

   // Widest generator state and the active width selected by mode 2'b00.
   localparam int W        = 11;
   localparam int MIN_BITS = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Expected period for an N-bit source: 2^N for a counter, 2^N-1 for a maximal LFSR.
   function automatic logic [11:0] exp_period(input logic [1:0] mode, input logic src_is_lfsr);
      logic [11:0] full;
      full = 12'd1 << (MIN_BITS + int'(mode));
      return src_is_lfsr ? full - 12'd1 : full;
   endfunction

   // Mask keeping only the active N low bits of the generator state.
   function automatic logic [W-1:0] width_mask(input logic [1:0] mode);
      logic [11:0] full;
      full = 12'd1 << (MIN_BITS + int'(mode));
      return W'(full - 12'd1);
   endfunction

endpackage

// File: rtl/seq_period_checker.sv
// Measures the recurrence period of a counter/LFSR state stream and grades it
// against the period expected for the latched width and source type.
module seq_period_checker
   import seq_chk_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1:0]    mode,
   input  logic          src_is_lfsr,
   input  logic          seq_valid,
   input  logic [W-1:0]  seq_in,
   output logic          busy,
   output logic          done,
   output logic [11:0]   period_out,
   output logic          pass,
   output logic          err_stuck,
   output logic          err_timeout
);

   state_t        state;
   logic [1:0]    mode_q;
   logic          src_q;
   logic [W-1:0]  ref_val;
   logic [W-1:0]  prev_val;
   logic [11:0]   cnt;

   logic [W-1:0]  sample;
   logic [11:0]   cnt_next;
   logic [11:0]   limit;
   logic [11:0]   expected;

   // Compares only ever see the active low bits; the upper generator bits are dropped here.
   assign sample   = seq_in & width_mask(mode_q);
   assign cnt_next = cnt + 12'd1;
   // The timeout bound is the counter period 2^N regardless of source type.
   assign limit    = exp_period(mode_q, 1'b0);
   assign expected = exp_period(mode_q, src_q);

   // Measurement FSM with registered status outputs; start overrides every state.
   // NOTE: state is updated with non-blocking assignments so every register sees
   // the pre-edge values of the others, matching the hardware it describes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mode_q      <= 2'b00;
         src_q       <= 1'b0;
         ref_val     <= '0;
         prev_val    <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         period_out  <= '0;
         pass        <= 1'b0;
         err_stuck   <= 1'b0;
         err_timeout <= 1'b0;
      end else if (start) begin
         // A sample arriving with start is deliberately not captured.
         state       <= ARM;
         mode_q      <= mode;
         src_q       <= src_is_lfsr;
         busy        <= 1'b1;
         done        <= 1'b0;
         period_out  <= '0;
         pass        <= 1'b0;
         err_stuck   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: ;
            ARM: begin
               if (seq_valid) begin
                  ref_val  <= sample;
                  prev_val <= sample;
                  cnt      <= '0;
                  state    <= MEASURE;
               end
            end
            MEASURE: begin
               if (seq_valid) begin
                  if (sample == ref_val) begin
                     period_out <= cnt_next;
                     pass       <= (cnt_next == expected);
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     state      <= DONE;
                  end else if (sample == prev_val) begin
                     period_out <= cnt_next;
                     err_stuck  <= 1'b1;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     state      <= DONE;
                  end else if (cnt_next == limit) begin
                     period_out  <= cnt_next;
                     err_timeout <= 1'b1;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     cnt      <= cnt_next;
                     prev_val <= sample;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_period_checker.sv
// Self-checking bench: a sample-history model predicts every output each cycle,
// and directed literal checks pin the model on the key scenarios.
module tb_seq_period_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        src_is_lfsr = 1'b0;
   logic        seq_valid = 1'b0;
   logic [10:0] seq_in = '0;
   logic        busy, done, pass, err_stuck, err_timeout;
   logic [11:0] period_out;

   int n_tests = 0;
   int n_fail  = 0;

   seq_period_checker dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src_is_lfsr(src_is_lfsr),
      .seq_valid(seq_valid), .seq_in(seq_in), .busy(busy), .done(done),
      .period_out(period_out), .pass(pass), .err_stuck(err_stuck), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int required);
      n_tests++;
      if (actual != required) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 waiting for reference, 2 measuring, 3 reporting
   int   m_phase = 0, m_bits = 8, m_n = 0;
   bit   m_lfsr = 0;
   int   hist [0:2047];
   int   m_period = 0;
   bit   m_busy = 0, m_done = 0, m_pass = 0, m_stuck = 0, m_tmo = 0;

   function automatic int kept(input int v, input int bits);
      return v % (2 ** bits);
   endfunction

   function automatic int want(input int bits, input bit lfsr);
      return lfsr ? (2 ** bits) - 1 : (2 ** bits);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_n <= 0; m_period <= 0;
         m_busy <= 0; m_done <= 0; m_pass <= 0; m_stuck <= 0; m_tmo <= 0;
      end else if (start) begin
         m_phase <= 1; m_bits <= 8 + int'(mode); m_lfsr <= src_is_lfsr;
         m_busy <= 1; m_done <= 0; m_period <= 0; m_pass <= 0; m_stuck <= 0; m_tmo <= 0;
      end else if (m_phase == 1 && seq_valid) begin
         hist[0] <= kept(int'(seq_in), m_bits);
         m_n     <= 0;
         m_phase <= 2;
      end else if (m_phase == 2 && seq_valid) begin
         if (kept(int'(seq_in), m_bits) == hist[0]) begin
            m_period <= m_n + 1;
            m_pass   <= (m_n + 1 == want(m_bits, m_lfsr));
            m_done <= 1; m_busy <= 0; m_phase <= 3;
         end else if (kept(int'(seq_in), m_bits) == hist[m_n]) begin
            m_period <= m_n + 1; m_stuck <= 1;
            m_done <= 1; m_busy <= 0; m_phase <= 3;
         end else if (m_n + 1 == 2 ** m_bits) begin
            m_period <= m_n + 1; m_tmo <= 1;
            m_done <= 1; m_busy <= 0; m_phase <= 3;
         end else begin
            hist[m_n + 1] <= kept(int'(seq_in), m_bits);
            m_n <= m_n + 1;
         end
      end else if (m_phase == 3) begin
         m_done  <= 0;
         m_phase <= 0;
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      check("busy",        int'(busy),        int'(m_busy));
      check("done",        int'(done),        int'(m_done));
      check("period_out",  int'(period_out),  m_period);
      check("pass",        int'(pass),        int'(m_pass));
      check("err_stuck",   int'(err_stuck),   int'(m_stuck));
      check("err_timeout", int'(err_timeout), int'(m_tmo));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] m, input logic s);
      start = 1'b1; mode = m; src_is_lfsr = s;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input int v);
      seq_in = 11'(v); seq_valid = 1'b1;
      tick();
      seq_valid = 1'b0;
   endtask

   task automatic expect_result(input string tag, input int per, input int ps,
                                input int stk, input int tmo);
      check({tag, "_done"},    int'(done),        1);
      check({tag, "_period"},  int'(period_out),  per);
      check({tag, "_pass"},    int'(pass),        ps);
      check({tag, "_stuck"},   int'(err_stuck),   stk);
      check({tag, "_timeout"}, int'(err_timeout), tmo);
   endtask

   logic [8:0] lfsr;
   int         budget;

   initial begin
      tick(); tick();
      check("reset_busy",   int'(busy),       0);
      check("reset_period", int'(period_out), 0);
      rst_n = 1'b1;
      tick();

      // T1: 8-bit counter, mode input changed after start must not matter.
      do_start(2'b00, 1'b0);
      mode = 2'b11;
      for (int v = 0; v < 256; v++) feed(v);
      feed(0);
      expect_result("t1", 256, 1, 0, 0);
      tick();
      check("t1_done_one_cycle", int'(done), 0);
      check("t1_period_held", int'(period_out), 256);

      // T2: maximal 9-bit LFSR, taps 9 and 5, seed 1.
      do_start(2'b01, 1'b1);
      lfsr   = 9'd1;
      budget = 0;
      while (!done && budget < 600) begin
         feed(int'(lfsr));
         lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
         budget++;
      end
      expect_result("t2", 511, 1, 0, 0);
      tick();

      // T3a: a repeated reference value is a recurrence after one sample.
      do_start(2'b00, 1'b0);
      feed(8'h05); feed(8'h05);
      expect_result("t3a", 1, 0, 0, 0);
      // T3b: a repeat that is not the reference is a stuck sequence.
      do_start(2'b00, 1'b0);
      feed(8'h05); feed(8'h06); feed(8'h06);
      expect_result("t3b", 2, 0, 1, 0);

      // T4: alternating values never recur, timeout at 2^8 samples.
      do_start(2'b00, 1'b0);
      feed(8'h05);
      for (int i = 0; i < 256; i++) feed((i % 2 == 0) ? 8'h06 : 8'h07);
      expect_result("t4", 256, 0, 0, 1);
      tick();

      // T5: upper bits are ignored, 0x012 matches reference 0x312.
      do_start(2'b00, 1'b0);
      feed(11'h312); feed(11'h7A0); feed(11'h0FF); feed(11'h012);
      expect_result("t5", 3, 0, 0, 0);
      tick();

      // T6a: restart mid-measure returns to arming with cleared status.
      do_start(2'b00, 1'b0);
      feed(1); feed(2); feed(3);
      do_start(2'b00, 1'b0);
      check("t6_restart_busy", int'(busy), 1);
      check("t6_restart_done", int'(done), 0);
      // A sample coinciding with start is not used as the reference.
      start = 1'b1; seq_in = 11'h0AA; seq_valid = 1'b1;
      tick();
      start = 1'b0; seq_valid = 1'b0;
      feed(8'h10); feed(8'h11); feed(8'h10);
      expect_result("t6_start_wins", 2, 0, 0, 0);
      tick();

      // T6b: reset mid-measure clears outputs without waiting for a clock edge.
      do_start(2'b10, 1'b0);
      feed(4); feed(5);
      #2 rst_n = 1'b0;
      #1;
      check("t6_reset_busy", int'(busy), 0);
      check("t6_reset_done", int'(done), 0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      check("t6_after_reset_done", int'(done), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
